// File: rtl/mux_arb_pkg.sv
// Shared types, constants and the round-robin search used by the 4-way lane arbiter.
package mux_arb_pkg;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned SEL_W = 2;

  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StGrant = 1'b1
  } state_e;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } rr_t;

  // First set bit of req searching ptr+1, ptr+2, ... wrapping; ptr itself is checked last.
  function automatic rr_t next_rr(input logic [N_REQ-1:0] req, input logic [SEL_W-1:0] ptr);
    rr_t              r;
    logic [SEL_W-1:0] c;
    r = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      c = ptr + SEL_W'(k);
      if (req[c]) begin
        r.found = 1'b1;
        r.idx   = c;
      end
    end
    return r;
  endfunction

  function automatic logic [N_REQ-1:0] sel_to_onehot(input logic [SEL_W-1:0] idx);
    return N_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/mux_4_1.sv
// Plain combinational 4:1 bit multiplexer forming the arbiter's data path.
module mux_4_1 (
  input  logic [3:0] i,
  input  logic [1:0] sel,
  output logic       y
);

  assign y = i[sel];

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one mux_4_1 lane among four requesters, with capped burst lock
// and a valid/ready handshake towards the consumer.
module mux4_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] lock,
  input  logic [N_REQ-1:0] data_in,
  input  logic             out_ready,
  output logic             out_valid,
  output logic             out_data,
  output logic [SEL_W-1:0] sel,
  output logic [N_REQ-1:0] gnt,
  output logic [N_REQ-1:0] ack
);

  localparam logic [3:0] HoldLast = 4'(MAX_HOLD - 1);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [3:0]       beat_cnt_q, beat_cnt_d;

  logic hs;
  logic mux_y;
  rr_t  pick_any;
  rr_t  pick_other;

  assign out_valid  = (state_q == StGrant);
  assign hs         = out_valid & out_ready;
  assign pick_any   = next_rr(req, ptr_q);
  assign pick_other = next_rr(req & ~gnt_q, ptr_q);

  mux_4_1 u_mux (
    .i   (data_in),
    .sel (sel_q),
    .y   (mux_y)
  );

  assign out_data = mux_y & out_valid;
  assign sel      = sel_q;
  assign gnt      = gnt_q;
  // Reset wins over a pending handshake so no beat is reported as consumed.
  assign ack      = (hs && !rst) ? gnt_q : '0;

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    ptr_d      = ptr_q;
    gnt_d      = gnt_q;
    beat_cnt_d = beat_cnt_q;

    unique case (state_q)
      StIdle: begin
        if (pick_any.found) begin
          state_d    = StGrant;
          sel_d      = pick_any.idx;
          gnt_d      = sel_to_onehot(pick_any.idx);
          ptr_d      = pick_any.idx;
          beat_cnt_d = '0;
        end
      end

      StGrant: begin
        if (hs) begin
          if (lock[sel_q] && req[sel_q] && (beat_cnt_q < HoldLast)) begin
            beat_cnt_d = beat_cnt_q + 4'd1;
          end else if (pick_other.found) begin
            sel_d      = pick_other.idx;
            gnt_d      = sel_to_onehot(pick_other.idx);
            ptr_d      = pick_other.idx;
            beat_cnt_d = '0;
          end else if (req[sel_q]) begin
            beat_cnt_d = '0;
          end else begin
            state_d    = StIdle;
            gnt_d      = '0;
            beat_cnt_d = '0;
          end
        end else if (!req[sel_q]) begin
          // Abort: ptr keeps the dropped index so it goes to the back of the queue.
          state_d    = StIdle;
          gnt_d      = '0;
          beat_cnt_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      sel_q      <= '0;
      ptr_q      <= SEL_W'(N_REQ - 1);
      gnt_q      <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter that shares one 4:1 mux output lane among four 1-bit requesters.
- Registers the mux select and one-hot grant, and presents the selected bit downstream under a valid/ready handshake.
- Optional per-requester lock allows bursts, capped at MAX_HOLD beats.
- Sits between four single-bit producers and one consumer; the data path is the existing mux_4_1.

Parameters:
- MAX_HOLD, 4, maximum consecutive accepted beats one grantee may hold while locked (legal range 1..15).

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous reset, active-high
- req  input  4  request per requester, bit n = requester n
- lock  input  4  per-requester burst-hold request, sampled at handshake
- data_in  input  4  data bit per requester, feeds mux_4_1 i
- out_ready  input  1  consumer ready
- out_valid  output  1  beat valid to consumer
- out_data  output  1  selected data bit
- sel  output  2  registered mux select, index of grantee
- gnt  output  4  registered one-hot grant, all-zero when idle
- ack  output  4  one-hot pulse: requester's beat accepted this cycle

Behaviour:
- Reset (synchronous, rst high at clk edge):
  - state=IDLE, gnt=0, sel=0, out_valid=0, beat_cnt=0.
  - ptr=3, so requester 0 has first priority.
  - rst overrides everything, including mid-burst: no ack is issued in the reset cycle.
- State IDLE:
  - out_valid=0.
  - If req!=0, pick the first set bit searching ptr+1, ptr+2, ... (mod 4).
  - Next edge: load sel/gnt, ptr=winner, beat_cnt=0, go GRANT.
  - Arbitration latency: 1 cycle from req to out_valid.
- State GRANT:
  - out_valid=1.
  - out_data = mux_4_1(data_in, sel), combinational from data_in.
  - out_data=0 whenever out_valid=0.
- Handshake:
  - hs = out_valid & out_ready.
  - ack = gnt when hs, else 0. Combinational, same cycle as hs.
- On hs, evaluated in this order:
  - a) Hold: if lock[sel] & req[sel] & (beat_cnt < MAX_HOLD-1), keep grant and increment beat_cnt.
  - b) Re-arbitrate: else if req has any bit set excluding sel, grant the next one round-robin from ptr.
    - Back-to-back, no idle bubble; beat_cnt=0; ptr=new winner.
  - c) Re-grant self: else if req[sel] still set, re-grant the same requester with beat_cnt=0.
    - It is the only requester, so there is no starvation.
  - d) Otherwise go IDLE, gnt=0.
- No handshake while in GRANT:
  - If req[sel] stays high, hold everything.
  - sel, gnt and out_valid are stable until accepted.
- Abort: req[sel] low in GRANT without hs.
  - Next edge: go IDLE, gnt=0, no ack.
  - ptr keeps the aborted index, so it loses priority.
- Protocol: a requester holds req until its ack. data_in[sel] must be stable while out_valid & !out_ready.
- beat_cnt is 4 bits and never wraps; MAX_HOLD=1 disables bursting.
- Simultaneous requests from all four: grant order cycles 0,1,2,3,0,... (each single-beat, lock=0).
- lock from non-granted requesters is ignored.

Decomposition:
- Shared package mux_arb_pkg:
  - state encoding (IDLE=0, GRANT=1);
  - N_REQ=4 and SEL_W=2 constants;
  - next_rr(req, ptr) function returning the index plus a found flag.
- Sub-module: one instance of the existing mux_4_1 (i=data_in, sel=sel, y gated by out_valid).
- Arbiter FSM, ptr and beat_cnt stay in this module.

Test Plan:
1. rst=1 for 2 cycles, then req=0 → out_valid=0, gnt=0, sel=0, ack=0 every cycle.
2. req=4'b1111, lock=0, out_ready=1, data_in=4'b0101 → gnt sequence 0001,0010,0100,1000,0001, one per cycle after the 1-cycle latency; out_data 1,0,1,0.
3. req=4'b0100, lock=4'b0100, MAX_HOLD=4, req[0] raised at the 2nd beat, out_ready=1 → four acks to requester 2, then gnt=0001 with no idle bubble.
4. req=4'b0010, out_ready=0 for 5 cycles, then 1 → out_valid, sel=1 and gnt=0010 are stable for 5 cycles; ack=0010 in exactly the ready cycle.
5. Granted requester 3 drops req with out_ready=0, while req[1]=1 → next cycle IDLE, no ack; the following cycle gnt=0010.
6. rst asserted mid-burst (requester 2 locked, beat_cnt=2) → next cycle out_valid=0, gnt=0; after release with req=4'b0101, requester 0 is granted first.
